skut_frame_serializer: RTL and testbench

// - Downstream of the SKUT frame former. Captures its 80-byte channel writes (iData/iAddr/iWrEn)

---
 rtl/skut_frame_serializer_pkg.sv | 25 ++
 rtl/skut_pingpong_ram.sv | 42 ++++
 rtl/skut_frame_serializer.sv | 173 +++++++++++++++++
 tb/tb_skut_frame_serializer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/skut_frame_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : skut_frame_serializer_pkg
// Description : Shared SKUT framing constants and serializer FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package skut_frame_serializer_pkg;

  localparam int SKUT_FRAME_BYTES   = 80;
  localparam int SKUT_FRAME_RATE_HZ = 8000;
  localparam int SKUT_ADDR_W        = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SYNC = 2'd2,
    ST_DATA = 2'd3
  } ser_state_e;

  function automatic int skut_frame_bits(input int sync_len, input int frame_bytes);
    return sync_len + 8 * frame_bytes;
  endfunction

endpackage
`default_nettype wire

// File: rtl/skut_pingpong_ram.sv
`default_nettype none
// ============================================================================
// Module      : skut_pingpong_ram
// Description : Two-bank simple dual-port byte RAM with registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
module skut_pingpong_ram
  import skut_frame_serializer_pkg::*;
#(
  parameter int DEPTH = SKUT_FRAME_BYTES
) (
  input  logic                   iClk,
  input  logic                   i_wr_en,
  input  logic                   i_wr_bank,
  input  logic [SKUT_ADDR_W-1:0] i_wr_addr,
  input  logic [7:0]             i_wr_data,
  input  logic                   i_rd_en,
  input  logic                   i_rd_bank,
  input  logic [SKUT_ADDR_W-1:0] i_rd_addr,
  output logic [7:0]             o_rd_data
);

  logic [7:0] r_mem [0:1][0:DEPTH-1];
  logic [7:0] r_rd_data;

  always_ff @(posedge iClk) begin
    if (i_wr_en) begin
      r_mem[i_wr_bank][i_wr_addr] <= i_wr_data;
    end
  end

  // Output register holds its value between reads and doubles as the prefetch.
  always_ff @(posedge iClk) begin
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_bank][i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/skut_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module      : skut_frame_serializer
// Description : Ping-pong buffers SKUT frames and shifts them out MSB-first.
// Revision    : 1.0 - initial release
// ============================================================================
module skut_frame_serializer
  import skut_frame_serializer_pkg::*;
#(
  parameter int          FRAME_BYTES = SKUT_FRAME_BYTES,
  parameter int          SYNC_LEN    = 16,
  parameter logic [15:0] SYNC_WORD   = 16'hE2F0,
  parameter logic        IDLE_LEVEL  = 1'b0
) (
  input  logic       iClk,
  input  logic       reset,
  input  logic       i8KHz,
  input  logic [7:0] iData,
  input  logic [6:0] iAddr,
  input  logic       iWrEn,
  input  logic       iBitEn,
  output logic       oSerial,
  output logic       oFrameSync,
  output logic       oBusy,
  output logic       oOverrun
);

  localparam logic [6:0] c_frame_bytes = 7'(FRAME_BYTES);
  localparam logic [6:0] c_last_byte   = 7'(FRAME_BYTES - 1);
  localparam logic [3:0] c_sync_last   = 4'(SYNC_LEN - 1);
  localparam logic [3:0] c_byte_last   = 4'd7;

  ser_state_e  r_state, w_next_state;
  logic [1:0]  r_s8k;
  logic        w_swap;
  logic        r_wr_bank, r_rd_bank;
  logic [15:0] r_shreg;
  logic [3:0]  r_bit_cnt;
  logic [6:0]  r_byte_idx;
  logic        r_serial, r_frame_sync, r_busy, r_overrun;
  logic        w_wr_en, w_rd_req, w_rd_en;
  logic [6:0]  w_rd_addr;
  logic [7:0]  w_prefetch;
  logic        w_load_frame, w_shift, w_load_byte, w_last_bit, w_idle_bit;

  assign w_swap  = (r_s8k == 2'b01);
  assign w_wr_en = iWrEn && (iAddr < c_frame_bytes);
  assign w_rd_en = w_rd_req && (w_rd_addr < c_frame_bytes);

  skut_pingpong_ram #(
    .DEPTH (FRAME_BYTES)
  ) u_ram (
    .iClk      (iClk),
    .i_wr_en   (w_wr_en),
    .i_wr_bank (r_wr_bank),
    .i_wr_addr (iAddr),
    .i_wr_data (iData),
    .i_rd_en   (w_rd_en),
    .i_rd_bank (r_rd_bank),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_prefetch)
  );

  always_ff @(posedge iClk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A swap overrides any pending bit strobe and restarts the frame.
  always_comb begin
    w_next_state = r_state;
    w_load_frame = 1'b0;
    w_shift      = 1'b0;
    w_load_byte  = 1'b0;
    w_last_bit   = 1'b0;
    w_idle_bit   = 1'b0;
    w_rd_req     = 1'b0;
    w_rd_addr    = '0;
    if (w_swap) begin
      w_next_state = ST_LOAD;
    end else begin
      case (r_state)
        ST_IDLE: w_idle_bit = iBitEn;
        ST_LOAD: begin
          w_load_frame = 1'b1;
          w_rd_req     = 1'b1;
          w_next_state = ST_SYNC;
        end
        ST_SYNC: if (iBitEn) begin
          w_shift = 1'b1;
          if (r_bit_cnt == c_sync_last) begin
            w_load_byte  = 1'b1;
            w_rd_req     = 1'b1;
            w_rd_addr    = 7'd1;
            w_next_state = ST_DATA;
          end
        end
        ST_DATA: if (iBitEn) begin
          w_shift = 1'b1;
          if (r_bit_cnt == c_byte_last) begin
            if (r_byte_idx == c_last_byte) begin
              w_last_bit   = 1'b1;
              w_next_state = ST_IDLE;
            end else begin
              w_load_byte = 1'b1;
              w_rd_req    = 1'b1;
              w_rd_addr   = r_byte_idx + 7'd2;
            end
          end
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (!reset) begin
      r_s8k        <= '0;
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_shreg      <= '0;
      r_bit_cnt    <= '0;
      r_byte_idx   <= '0;
      r_serial     <= IDLE_LEVEL;
      r_frame_sync <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_s8k     <= {r_s8k[0], i8KHz};
      r_overrun <= w_swap && r_busy;
      if (w_swap) begin
        r_rd_bank <= r_wr_bank;
        r_wr_bank <= ~r_wr_bank;
      end
      if (w_load_frame) begin
        r_shreg    <= SYNC_WORD;
        r_bit_cnt  <= '0;
        r_byte_idx <= '0;
        r_busy     <= 1'b1;
      end
      if (w_shift) begin
        r_serial     <= r_shreg[15];
        r_frame_sync <= (r_state == ST_SYNC) && (r_bit_cnt == 4'd0);
        r_shreg      <= {r_shreg[14:0], 1'b0};
        r_bit_cnt    <= r_bit_cnt + 4'd1;
      end
      if (w_load_byte) begin
        r_shreg   <= {w_prefetch, 8'h00};
        r_bit_cnt <= '0;
        if (r_state == ST_DATA) begin
          r_byte_idx <= r_byte_idx + 7'd1;
        end
      end
      if (w_last_bit) begin
        r_busy <= 1'b0;
      end
      if (w_idle_bit) begin
        r_serial     <= IDLE_LEVEL;
        r_frame_sync <= 1'b0;
      end
    end
  end

  assign oSerial    = r_serial;
  assign oFrameSync = r_frame_sync;
  assign oBusy      = r_busy;
  assign oOverrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_skut_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_skut_frame_serializer
// Description : Directed self-checking bench for skut_frame_serializer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_skut_frame_serializer;

  localparam int   FRAME_BITS = 656;
  localparam logic IDLE_LVL   = 1'b0;

  logic       iClk, reset, i8KHz, iWrEn, iBitEn;
  logic [7:0] iData;
  logic [6:0] iAddr;
  logic       oSerial, oFrameSync, oBusy, oOverrun;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int bit_period = 1;
  logic last_en;
  int model_wr = 0;
  logic [7:0] exp_mem [0:1][0:79];

  skut_frame_serializer dut (
    .iClk       (iClk),
    .reset      (reset),
    .i8KHz      (i8KHz),
    .iData      (iData),
    .iAddr      (iAddr),
    .iWrEn      (iWrEn),
    .iBitEn     (iBitEn),
    .oSerial    (oSerial),
    .oFrameSync (oFrameSync),
    .oBusy      (oBusy),
    .oOverrun   (oOverrun)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    iBitEn  = (bit_period <= 1) ? 1'b1 : ((cyc % bit_period) == 0);
    last_en = iBitEn;
    @(posedge iClk);
    #1;
    cyc++;
  endtask

  function automatic logic [7:0] pat(input int p, input int a);
    logic [7:0] v;
    v = 8'(a);
    case (p)
      0:       return v;
      1:       return v ^ 8'hA5;
      2:       return ~v;
      3:       return 8'(a * 3 + 7);
      default: return {v[3:0], v[7:4]} ^ 8'h3C;
    endcase
  endfunction

  function automatic logic exp_bit(input int rd, input int k);
    logic [15:0] sw;
    logic [7:0]  b;
    sw = 16'hE2F0;
    if (k < 16) return sw[15-k];
    b = exp_mem[rd][(k-16)/8];
    return b[7-((k-16)%8)];
  endfunction

  task automatic wr_byte(input int addr, input logic [7:0] data);
    iWrEn = 1'b1;
    iAddr = 7'(addr);
    iData = data;
    tick();
    iWrEn = 1'b0;
    if (addr < 80) exp_mem[model_wr][addr] = data;
  endtask

  task automatic write_pattern(input int p);
    for (int a = 0; a < 80; a++) wr_byte(a, pat(p, a));
  endtask

  task automatic idle_check(input string tag, input int n);
    int errs;
    errs = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (oSerial !== IDLE_LVL || oBusy !== 1'b0 || oFrameSync !== 1'b0 || oOverrun !== 1'b0) errs++;
    end
    chk(tag, errs, 0);
  endtask

  // Raise the strobe, then check nbits of the emitted stream against the bank model.
  task automatic capture(input int period, input int nbits, input bit full,
                         input int exp_ovr, input int bg_pat, input string tag);
    int rd, waited, ovr, bit_errs, fs_errs, busy_errs, wi, guard;
    logic prev;
    bit_period = period;
    i8KHz = 1'b0;
    tick();
    tick();
    i8KHz = 1'b1;
    rd = model_wr;
    model_wr ^= 1;
    waited = 0;
    ovr = 0;
    while (oFrameSync !== 1'b1 && waited < 40) begin
      tick();
      waited++;
      if (oOverrun === 1'b1) ovr++;
    end
    i8KHz = 1'b0;
    if (waited >= 40) begin
      chk({tag, "_fs_timeout"}, waited, 0);
      return;
    end
    if (period == 1) chk({tag, "_latency"}, waited, 4);
    bit_errs  = (oSerial !== exp_bit(rd, 0)) ? 1 : 0;
    busy_errs = (oBusy !== 1'b1) ? 1 : 0;
    fs_errs   = 0;
    wi = 0;
    prev = oSerial;
    for (int k = 1; k < nbits; k++) begin
      guard = 0;
      do begin
        if (bg_pat >= 0 && wi < 80 && k >= 8) begin
          iWrEn = 1'b1;
          iAddr = 7'(wi);
          iData = pat(bg_pat, wi);
          exp_mem[model_wr][wi] = iData;
          wi++;
        end else begin
          iWrEn = 1'b0;
        end
        tick();
        guard++;
        if (!last_en && oSerial !== prev) bit_errs++;
        if (oOverrun === 1'b1) ovr++;
      end while (!last_en && guard < 16);
      if (oSerial !== exp_bit(rd, k)) bit_errs++;
      if (oFrameSync !== 1'b0) fs_errs++;
      if (oBusy !== ((k == FRAME_BITS - 1) ? 1'b0 : 1'b1)) busy_errs++;
      prev = oSerial;
    end
    iWrEn = 1'b0;
    chk({tag, "_bits"}, bit_errs, 0);
    chk({tag, "_framesync"}, fs_errs, 0);
    chk({tag, "_busy"}, busy_errs, 0);
    chk({tag, "_overrun"}, ovr, exp_ovr);
    if (full) begin
      guard = 0;
      do begin
        tick();
        guard++;
      end while (!last_en && guard < 16);
      chk({tag, "_idle_after"}, int'(oSerial), int'(IDLE_LVL));
    end
  endtask

  initial begin
    reset = 1'b0;
    i8KHz = 1'b0;
    iWrEn = 1'b0;
    iBitEn = 1'b0;
    iData = '0;
    iAddr = '0;

    // Reset state and quiet line before any swap
    repeat (5) tick();
    chk("rst_serial", int'(oSerial), int'(IDLE_LVL));
    chk("rst_busy", int'(oBusy), 0);
    chk("rst_overrun", int'(oOverrun), 0);
    chk("rst_framesync", int'(oFrameSync), 0);
    reset = 1'b1;
    model_wr = 0;
    idle_check("rst_idle", 20);

    // Basic frame: byte a = a
    write_pattern(0);
    capture(1, FRAME_BITS, 1'b1, 0, -1, "basic");

    // Ping-pong: A shifted while B is written, then B
    write_pattern(1);
    capture(1, FRAME_BITS, 1'b1, 0, 2, "pp_a");
    capture(1, FRAME_BITS, 1'b1, 0, -1, "pp_b");

    // Overrun after 300 bits restarts on the other bank
    write_pattern(3);
    capture(1, 300, 1'b0, 0, -1, "ovr_old");
    capture(1, FRAME_BITS, 1'b1, 1, -1, "ovr_new");

    // Out-of-range writes ignored, held write is idempotent
    wr_byte(80, 8'hFF);
    wr_byte(127, 8'hFF);
    iWrEn = 1'b1;
    iAddr = 7'd5;
    iData = 8'hA5;
    repeat (8) tick();
    iWrEn = 1'b0;
    exp_mem[model_wr][5] = 8'hA5;
    capture(1, FRAME_BITS, 1'b1, 0, -1, "bounds");

    // Slow bit rate, reset mid-DATA, then a clean frame
    write_pattern(4);
    capture(4, 100, 1'b0, 0, -1, "slow");
    reset = 1'b0;
    tick();
    chk("midrst_serial", int'(oSerial), int'(IDLE_LVL));
    chk("midrst_busy", int'(oBusy), 0);
    chk("midrst_framesync", int'(oFrameSync), 0);
    reset = 1'b1;
    model_wr = 0;
    idle_check("midrst_idle", 20);
    capture(2, FRAME_BITS, 1'b1, 0, -1, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
